// File: rtl/dig_pkg.sv
// Shared constants for the eight-digit multiplexed seven-segment scanner:
// character codes, segment patterns (active-low {g,f,e,d,c,b,a}) and helpers.
package dig_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int CODE_W     = 5;
  localparam int DP_BIT     = 4;

  typedef logic [CODE_W-1:0] char_t;

  localparam char_t CH_H     = 5'h0A;
  localparam char_t CH_E     = 5'h0B;
  localparam char_t CH_L     = 5'h0C;
  localparam char_t CH_O     = 5'h0D;
  localparam char_t CH_BLANK = 5'h0F;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_H     = 7'b0001001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_L     = 7'b1000111;
  localparam logic [6:0] SEG_O     = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Letters and blanks terminate a run of leading zeros.
  function automatic logic is_non_numeric(input char_t code);
    return code[3:0] >= 4'hA;
  endfunction

endpackage

// File: rtl/seg7_enc.sv
// Combinational character decoder: 5-bit code plus suppress flag to
// active-low segments and decimal point.
module seg7_enc
  import dig_pkg::*;
(
  input  logic [4:0] code_i,
  input  logic       suppress_i,
  output logic [6:0] seg_o,
  output logic       dp_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    dp_o  = 1'b1;
    if (!suppress_i) begin
      dp_o = ~code_i[DP_BIT];
      case (code_i[3:0])
        4'h0:        seg_o = SEG_0;
        4'h1:        seg_o = SEG_1;
        4'h2:        seg_o = SEG_2;
        4'h3:        seg_o = SEG_3;
        4'h4:        seg_o = SEG_4;
        4'h5:        seg_o = SEG_5;
        4'h6:        seg_o = SEG_6;
        4'h7:        seg_o = SEG_7;
        4'h8:        seg_o = SEG_8;
        4'h9:        seg_o = SEG_9;
        CH_H[3:0]:   seg_o = SEG_H;
        CH_E[3:0]:   seg_o = SEG_E;
        CH_L[3:0]:   seg_o = SEG_L;
        CH_O[3:0]:   seg_o = SEG_O;
        default:     seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/dig_scan.sv
// Eight-digit multiplexed display scanner with frame snapshot and ghost blanking.
// Optional leading-zero suppression is enabled by defining LZ_SUPPRESS_EN.
module dig_scan
  import dig_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [39:0] dig,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int CNT_W = $clog2(SCAN_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [39:0]      snap_q, snap_d;
  logic             valid_q, valid_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             tick_q, tick_d;

  logic             slot_end, frame_end, blank_win;
  char_t            chars [NUM_DIGITS];
  logic [7:0]       supp;
  logic [6:0]       enc_seg;
  logic             enc_dp;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_chars
    assign chars[g] = snap_q[CODE_W*g +: CODE_W];
  end

`ifdef LZ_SUPPRESS_EN
  // Suppression ripples down from the leftmost position.
  always_comb begin
    supp = '0;
    supp[NUM_DIGITS-1] = (chars[NUM_DIGITS-1] == 5'h00);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      supp[i] = (chars[i] == 5'h00) && (supp[i+1] || is_non_numeric(chars[i+1]));
    end
  end
`else
  assign supp = '0;
`endif

  seg7_enc u_enc (
    .code_i     (chars[idx_q]),
    .suppress_i (supp[idx_q]),
    .seg_o      (enc_seg),
    .dp_o       (enc_dp)
  );

  assign slot_end  = (cnt_q == CNT_W'(SCAN_DIV - 1));
  assign frame_end = slot_end && (idx_q == 3'd7);
  assign blank_win = (cnt_q < CNT_W'(BLANK_CYC));

  always_comb begin
    cnt_d   = slot_end ? '0 : cnt_q + CNT_W'(1);
    idx_d   = slot_end ? idx_q + 3'd1 : idx_q;
    snap_d  = frame_end ? dig : snap_q;
    valid_d = valid_q | frame_end;
    tick_d  = frame_end;
    an_d    = 8'hFF;
    seg_d   = SEG_BLANK;
    dp_d    = 1'b1;
    // Anodes stay dark until the first real snapshot has been captured.
    if (valid_q && !blank_win) begin
      an_d  = ~(8'b1 << idx_q);
      seg_d = enc_seg;
      dp_d  = enc_dp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      snap_q  <= {NUM_DIGITS{CH_BLANK}};
      valid_q <= 1'b0;
      an_q    <= 8'hFF;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      valid_q <= valid_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      tick_q  <= tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_dig_scan.sv
// Scoreboard bench for dig_scan: per-cycle expectations from a cycle-count
// reference model are queued by the stimulus and checked by a separate monitor.
module tb_dig_scan;

  localparam int DIV = 8;
  localparam int BLK = 2;
  localparam int FR  = DIV * 8;

`ifdef LZ_SUPPRESS_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ft;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [39:0] dig = '0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  int          n_checks = 0;
  int          n_fail = 0;
  int          k = 0;
  int          k_last = -1;
  logic [39:0] hist [int];
  exp_t        sb [$];

  dig_scan #(.SCAN_DIV(DIV), .BLANK_CYC(BLK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dig        (dig),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [39:0] act, logic [39:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (k=%0d t=%0t)", nm, act, expv, k_last, $time);
    end
  endfunction

  function automatic logic [7:0] ref_disp(logic [4:0] c, bit blanked);
    logic [6:0] s;
    if (blanked) return 8'hFF;
    case (c[3:0])
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h09;  4'hB: s = 7'h06;
      4'hC: s = 7'h47;  4'hD: s = 7'h40;  default: s = 7'h7F;
    endcase
    return {~c[4], s};
  endfunction

  // A zero is suppressed when every position from it up to the next
  // non-zero code (or the top) is 5'h00, and that non-zero code is a letter/blank.
  function automatic bit ref_suppressed(logic [39:0] s, int pos);
    logic [4:0] c;
    if (!LZ) return 1'b0;
    for (int j = pos; j < 8; j++) begin
      c = s[5*j +: 5];
      if (c != 5'h00) return (j > pos) && (c[3:0] >= 4'hA);
    end
    return 1'b1;
  endfunction

  // Outputs sampled after the k-th rising edge since reset release.
  function automatic exp_t model(int kk);
    exp_t        e;
    int          idx;
    logic [39:0] s;
    logic [4:0]  c;
    logic [7:0]  d;
    e.ft  = ((kk + 1) % FR == 0);
    e.an  = 8'hFF;
    e.seg = 7'h7F;
    e.dp  = 1'b1;
    if (kk >= FR && (kk % DIV) >= BLK) begin
      idx   = (kk / DIV) % 8;
      s     = hist[FR * (kk / FR) - 1];
      c     = s[5*idx +: 5];
      d     = ref_disp(c, ref_suppressed(s, idx));
      e.an  = ~(8'h01 << idx);
      e.seg = d[6:0];
      e.dp  = d[7];
    end
    return e;
  endfunction

  function automatic logic [39:0] rand_dig();
    logic [39:0] v;
    for (int i = 0; i < 8; i++)
      v[5*i +: 5] = ($urandom_range(0, 3) == 0) ? 5'h00 : 5'($urandom_range(0, 31));
    return v;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("an", {32'h0, an}, {32'h0, e.an});
        chk("seg", {33'h0, seg}, {33'h0, e.seg});
        chk("dp", {39'h0, dp}, {39'h0, e.dp});
        chk("frame_tick", {39'h0, frame_tick}, {39'h0, e.ft});
      end
      chk("one_anode", {39'h0, ($countones(~an) > 1)}, 40'h0);
    end
  end

  task automatic step();
    hist[k] = dig;
    @(posedge clk);
    sb.push_back(model(k));
    @(negedge clk);
    k_last = k;
    k++;
  endtask

  task automatic run(int n, bit chg);
    for (int i = 0; i < n; i++) begin
      step();
      if (chg && $urandom_range(0, 11) == 0) dig = rand_dig();
    end
  endtask

  task automatic run_until(int target);
    while (k_last < target) step();
  endtask

  task automatic check_disp(string nm, logic [7:0] ea, logic [6:0] es, logic ed);
    chk({nm, "_an"}, {32'h0, an}, {32'h0, ea});
    chk({nm, "_seg"}, {33'h0, seg}, {33'h0, es});
    chk({nm, "_dp"}, {39'h0, dp}, {39'h0, ed});
  endtask

  task automatic check_reset_vals(string nm);
    check_disp(nm, 8'hFF, 7'h7F, 1'b1);
    chk({nm, "_ft"}, {39'h0, frame_tick}, 40'h0);
  endtask

  initial begin
    int base;
    rst_n = 1'b0;
    dig   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;

    // Blank through the first 64 cycles, then the first snapshot of all zeros.
    run_until(FR - 2);
    chk("pre_snap_an", {32'h0, an}, 40'hFF);
    run_until(FR - 1);
    chk("first_tick", {39'h0, frame_tick}, 40'h1);
    run_until(FR + BLK);
    check_disp("first_digit", 8'hFE, LZ ? 7'h7F : 7'h40, 1'b1);

    run(FR * 5, 1'b1);

    // HELLO frame, with dig disturbed mid-frame to show no tearing.
    base = FR * (k / FR + 2);
    dig  = {5'h0A, 5'h0B, 5'h0C, 5'h0C, 5'h0D, 5'h00, 5'h10, 5'h05};
    run_until(base + BLK);
    check_disp("hello_p0", 8'hFE, 7'h12, 1'b1);
    run_until(base + DIV + 1);
    check_disp("hello_gap", 8'hFF, 7'h7F, 1'b1);
    run_until(base + DIV + 4);
    check_disp("hello_p1", 8'hFD, 7'h40, 1'b0);
    run_until(base + 2 * DIV + 4);
    check_disp("hello_p2", 8'hFB, LZ ? 7'h7F : 7'h40, 1'b1);
    dig = rand_dig();
    run_until(base + 7 * DIV + 3);
    check_disp("hello_p7", 8'h7F, 7'h09, 1'b1);

    run(FR * 3, 1'b1);

    // Asynchronous reset while idx = 3, cnt = 5.
    base = FR * (k / FR + 1);
    run_until(base + 3 * DIV + 4);
    chk("pre_reset_an", {32'h0, an}, 40'hF7);
    #1 rst_n = 1'b0;
    #1 check_reset_vals("async_reset");
    sb.delete();
    hist.delete();
    k = 0;
    k_last = -1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset_hold");
    rst_n = 1'b1;
    dig = rand_dig();
    run_until(FR - 1);
    chk("restart_tick", {39'h0, frame_tick}, 40'h1);
    run(FR * 3, 1'b1);

    @(negedge clk);
    @(negedge clk);
    chk("sb_drain", 40'(sb.size()), 40'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dig_scan.md
DIG_SCAN -- requirements
Module: dig_scan

Interface
REQ-001 Parameter SCAN_DIV, default 100000, clock cycles per digit slot (>= 4).
REQ-002 Parameter BLANK_CYC, default 2, anode-off cycles at the start of each slot (1 <= BLANK_CYC < SCAN_DIV).
REQ-003 Port clk  input  1  system clock; all state on its rising edge.
REQ-004 Port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 Port dig  input  40  eight 5-bit character codes; position i occupies dig[5i+4:5i]; position 0 is rightmost.
REQ-006 Port an  output  8  digit enables, active-low; an[i] drives position i.
REQ-007 Port seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-008 Port dp  output  1  decimal point, active-low.
REQ-009 Port frame_tick  output  1  one-cycle pulse when a new dig snapshot is taken.

Function
REQ-010 Code decode: bit4 = decimal point lit; low nibble 0-9 = digit, A = H, B = E, C = L, D = O, E/F = blank.
REQ-011 Patterns: 0/O = 1000000, 5 = 0010010, H = 0001001, E = 0000110, L = 1000111, blank = 1111111; remaining digits use standard 7-seg.
REQ-012 Prescaler cnt counts 0..SCAN_DIV-1, then wraps to 0.
REQ-013 When cnt == SCAN_DIV-1, digit index idx advances modulo 8 (7 -> 0).
REQ-014 On the 7 -> 0 advance, snap <= dig and frame_tick pulses high for that one cycle.
REQ-015 dig is sampled only at REQ-014; changes between snapshots do not affect the display (no tearing).
REQ-016 While cnt < BLANK_CYC: an = 8'hFF, seg = 7'h7F, dp = 1 (ghost suppression).
REQ-017 Otherwise: exactly one an bit low (an[idx]); seg/dp decode snap position idx.
REQ-018 an, seg, dp are registered; their value in cycle t+1 reflects idx/cnt/snap in cycle t.
REQ-019 Never more than one an bit low in any cycle, including at reset exit.

Reset
REQ-020 While rst_n is low: cnt = 0, idx = 0, an = 8'hFF, seg = 7'h7F, dp = 1, frame_tick = 0, snap = {8{5'h0F}} (all blank).
REQ-021 Reset asserted mid-slot forces REQ-020 values immediately, without waiting for a clock.
REQ-022 After release, the display stays blank until the first snapshot, SCAN_DIV*8 cycles later.

Configuration
REQ-023 Macro LZ_SUPPRESS_EN.
- Defined: position i is blanked when its code == 5'h00 and (i == 7, or position i+1 is blanked, or position i+1 has low nibble >= A).
- Evaluated on snap.
- Codes with bit4 set are never suppressed, so "0.5" stays visible.
REQ-024 Undefined: no suppression; 5'h00 displays "0".

Structure
REQ-025 Shared package dig_pkg: character code constants (CH_H = 5'h0A, CH_E = 5'h0B, CH_L = 5'h0C, CH_O = 5'h0D, CH_BLANK = 5'h0F, DP_BIT = 4), NUM_DIGITS = 8, segment pattern constants.
REQ-026 One combinational sub-module seg7_enc: 5-bit code plus suppress flag -> seg, dp.
REQ-027 Counters, snapshot and output registers live in dig_scan.

Verification (SCAN_DIV = 8, BLANK_CYC = 2 unless stated)
REQ-028 Reset release, dig = 0 -> an = FF for the first 64 cycles, then frame_tick pulses once and position 0 shows "0" (seg = 1000000).
REQ-029 dig = {H,E,L,L,O, 5'h00, 5'h10, 5'h05} -> one frame shows positions 7..0 as H,E,L,L,O,0,"0." (dp = 0),5, each for 6 lit cycles after 2 blank cycles.
REQ-030 Change dig mid-frame -> displayed characters do not change until the next frame_tick.
REQ-031 Any run, checked every cycle -> popcount(~an) <= 1; an = FF whenever cnt < 2.
REQ-032 Assert rst_n low at idx = 3, cnt = 5 -> same-cycle an = FF, seg = 7F; restart from idx = 0.
REQ-033 LZ_SUPPRESS_EN defined, dig = {H,E,L,L,O, 5'h00, 5'h10, 5'h05} -> position 2 blank, position 1 shows "0."; undefined -> position 2 shows "0".
